mem_ram_access: RTL and testbench
=================================

# mem_ram_access

Memory-access pipeline stage with an integrated byte-serial RAM port. It takes the EX/MEM latch contents and performs loads and stores against a single 8-bit-wide synchronous RAM, one byte per clock. It stalls the pipeline while a multi-byte access is in progress and presents the write-back triple to MEM/WB. Internally it combines a load/store byte sequencer, a RAM port arbiter (write over read) and a divide-by-2 clock output.

## Interface
- ALU_LB 6'h20, ALU_LH 6'h21, ALU_LW 6'h22, ALU_LBU 6'h23, ALU_LHU 6'h24: load opcodes on `aluop_i`.
- ALU_SB 6'h25, ALU_SH 6'h26, ALU_SW 6'h27: store opcodes on `aluop_i`. Any other value is a non-memory op.
- clk  in  1  system clock. All state changes on its rising edge.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- aluop_i  in  6  operation code.
- wreg_i  in  1  instruction writes a register.
- waddr_i  in  5  destination register.
- alurslt_i  in  32  ALU result: effective address for load/store, write-back value otherwise.
- storedata_i  in  32  store data.
- ram_rdata_i  in  8  RAM read byte. Valid the cycle after its address is driven.
- ram_addr_o  out  32  RAM byte address. The top level truncates it to 17 bits.
- ram_wdata_o  out  8  RAM write byte.
- ram_wr_o  out  1  1 = write, 0 = read.
- stall_o  out  1  an access is in progress; upstream holds its inputs stable.
- wreg_o  out  1  write-back enable.
- waddr_o  out  5  write-back register.
- wdata_o  out  32  write-back data.
- dclk  out  1  clk/2.

## Operation
- **States:** IDLE, LOAD, STORE, DONE, plus a byte index k. N = 1, 2 or 4 for byte, half and word.
- **IDLE:**
  - A load opcode goes to LOAD with k=0; a store opcode goes to STORE with k=0.
  - A non-memory op stays in IDLE: wreg_o=wreg_i, waddr_o=waddr_i, wdata_o=alurslt_i, stall_o=0, RAM idle.
- **Addressing:** A = alurslt_i. The byte-k address is A+k, 32-bit wrap-around, no alignment requirement. Byte order is little-endian.
- **Load:**
  - Cycles 0..N-1 drive read address A+k.
  - The byte returned for address A+k is captured into buffer byte k at the end of cycle k+1.
  - Cycle N drives no access.
  - The next state after that is DONE.
- **Store:**
  - Cycles 0..N-1 drive write address A+k, ram_wdata_o = storedata_i[8k+7:8k], ram_wr_o=1.
  - The next state is DONE.
- **DONE (one cycle):**
  - stall_o=0, waddr_o=waddr_i.
  - For loads, wreg_o=wreg_i and wdata_o is the buffer, extended as follows:
    - LB / LH: sign-extend from bit 7 / bit 15.
    - LBU / LHU: zero-extend.
    - LW: no extension.
  - For stores, wreg_o=0.
  - Next state is IDLE. A memory op still held at the inputs is started again; the upstream stage advances on stall_o=0.
- **During LOAD / STORE:** stall_o=1, wreg_o=0, wdata_o=0, waddr_o=0.
- **Arbiter (combinational):**
  - Write request active: ram_addr_o = write address, ram_wr_o=1.
  - Otherwise, read request active: ram_addr_o = read address, ram_wr_o=0.
  - Otherwise: ram_addr_o=0, ram_wr_o=0, ram_wdata_o=0.
- **Clock divider:** dclk register toggles on every clk edge; it is 0 after reset.

## Timing
- Load latency: stall_o is high for N+1 cycles; data is valid in cycle N+1 (DONE).
  - LW: 5 stall cycles, then DONE.
  - LB: 2 stall cycles, then DONE.
- Store: stall_o is high for N cycles, then DONE.
  - SW: 4 stall cycles.
- The opcode is sampled in IDLE only. Changes to aluop_i, alurslt_i or storedata_i mid-operation are a protocol violation; the sequencer uses the live inputs.
- **Reset:**
  - rst=1 forces outputs combinationally: stall_o=0, wreg_o=0, waddr_o=0, wdata_o=0, ram_addr_o=0, ram_wdata_o=0, ram_wr_o=0.
  - At the clock edge, the state returns to IDLE, the buffer clears and dclk clears.
  - Reset mid-access aborts it. Bytes already written stay written; a partial load is discarded.
- Read and write are never requested in the same cycle. The arbiter still gives write priority if they are.

## Test plan
- **SW then LW:** reset, then SW A=0, storedata=0x0FF00FF0.
  - RAM[0..3] = F0,0F,F0,0F; stall_o high 4 cycles.
  - Then LW A=0: stall_o high 5 cycles, DONE wdata_o=0x0FF00FF0, wreg_o=1.
- **Byte loads on that RAM image:**
  - LB A=0 → 0xFFFFFFF0.
  - LBU A=0 → 0x000000F0.
  - LB A=1 → 0x0000000F.
- **Half loads on that RAM image:**
  - LH A=1 (bytes 0F,F0) → 0xFFFFF00F.
  - LHU A=1 → 0x0000F00F.
  - LH A=0 → 0x00000FF0.
- **Non-memory op:** aluop=0, alurslt=0x12345678, waddr=5, wreg=1.
  - Same cycle: wdata_o=0x12345678, waddr_o=5, wreg_o=1, stall_o=0, ram_wr_o=0.
- **Reset mid-LW:**
  - Assert rst in cycle 2 of an LW.
  - Next cycle: all outputs 0, state IDLE.
  - A following LW A=0 completes normally in 5+1 cycles.
- **Clock divider:** dclk=0 after reset, toggles every clk rising edge (period 2 clk).

Source files
------------

// File: rtl/mem_ram_access.sv
// mem_ram_access
// Memory-access pipeline stage driving a byte-wide synchronous RAM.
// Loads and stores of 1, 2 or 4 bytes are serialised one byte per clock,
// little-endian, at consecutive addresses A+k (32-bit wrap). The stage
// stalls upstream while a transfer is in flight and presents the
// write-back triple to MEM/WB. A divide-by-2 clock is also produced.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   aluop_i         operation code (loads 0x20..0x24, stores 0x25..0x27)
//   wreg_i/waddr_i  write-back enable / destination register from EX/MEM
//   alurslt_i       effective address (memory ops) or result (other ops)
//   storedata_i     store data
//   ram_rdata_i     RAM read byte, valid the cycle after its address
//   ram_addr_o      RAM byte address
//   ram_wdata_o     RAM write byte
//   ram_wr_o        1 = write, 0 = read
//   stall_o         transfer in progress, upstream holds its inputs
//   wreg_o/waddr_o/wdata_o  write-back triple to MEM/WB
//   dclk            clk divided by 2
module mem_ram_access (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  aluop_i,
    input  logic        wreg_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] alurslt_i,
    input  logic [31:0] storedata_i,
    input  logic [7:0]  ram_rdata_i,
    output logic [31:0] ram_addr_o,
    output logic [7:0]  ram_wdata_o,
    output logic        ram_wr_o,
    output logic        stall_o,
    output logic        wreg_o,
    output logic [4:0]  waddr_o,
    output logic [31:0] wdata_o,
    output logic        dclk
);

    localparam logic [5:0] ALU_LB  = 6'h20;
    localparam logic [5:0] ALU_LH  = 6'h21;
    localparam logic [5:0] ALU_LW  = 6'h22;
    localparam logic [5:0] ALU_LBU = 6'h23;
    localparam logic [5:0] ALU_LHU = 6'h24;
    localparam logic [5:0] ALU_SB  = 6'h25;
    localparam logic [5:0] ALU_SH  = 6'h26;
    localparam logic [5:0] ALU_SW  = 6'h27;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_STORE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]  state_r;
    logic [2:0]  k_r;
    logic [31:0] load_buf_r;
    logic        dclk_r;

    logic        is_load_s;
    logic        is_store_s;
    logic [2:0]  nbytes_s;
    logic [31:0] byte_addr_s;
    logic [7:0]  store_byte_s;
    logic        rd_req_s;
    logic        wr_req_s;

    // Width extension of the assembled load buffer for the load flavour.
    function automatic logic [31:0] extend_load(input logic [5:0] op,
                                                input logic [31:0] raw);
        logic [31:0] res;
        case (op)
            ALU_LB:  res = {{24{raw[7]}}, raw[7:0]};
            ALU_LBU: res = {24'd0, raw[7:0]};
            ALU_LH:  res = {{16{raw[15]}}, raw[15:0]};
            ALU_LHU: res = {16'd0, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    // Opcode decode: access class and byte count from the live opcode.
    always_comb begin
        is_load_s  = 1'b0;
        is_store_s = 1'b0;
        nbytes_s   = 3'd1;
        case (aluop_i)
            ALU_LB, ALU_LBU: begin is_load_s  = 1'b1; nbytes_s = 3'd1; end
            ALU_LH, ALU_LHU: begin is_load_s  = 1'b1; nbytes_s = 3'd2; end
            ALU_LW:          begin is_load_s  = 1'b1; nbytes_s = 3'd4; end
            ALU_SB:          begin is_store_s = 1'b1; nbytes_s = 3'd1; end
            ALU_SH:          begin is_store_s = 1'b1; nbytes_s = 3'd2; end
            ALU_SW:          begin is_store_s = 1'b1; nbytes_s = 3'd4; end
            default:         begin nbytes_s   = 3'd1; end
        endcase
    end

    // Byte-k address and the store byte selected by k.
    always_comb begin
        byte_addr_s = alurslt_i + {29'd0, k_r};
        case (k_r)
            3'd0:    store_byte_s = storedata_i[7:0];
            3'd1:    store_byte_s = storedata_i[15:8];
            3'd2:    store_byte_s = storedata_i[23:16];
            3'd3:    store_byte_s = storedata_i[31:24];
            default: store_byte_s = 8'd0;
        endcase
    end

    // Byte sequencer: state, byte index and load buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            k_r        <= 3'd0;
            load_buf_r <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    k_r <= 3'd0;
                    if (is_load_s) begin
                        state_r    <= ST_LOAD;
                        load_buf_r <= 32'd0;
                    end else if (is_store_s) begin
                        state_r <= ST_STORE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    // Read data trails its address by one cycle, so the
                    // byte addressed at k-1 arrives while k is current.
                    case (k_r)
                        3'd1:    load_buf_r[7:0]   <= ram_rdata_i;
                        3'd2:    load_buf_r[15:8]  <= ram_rdata_i;
                        3'd3:    load_buf_r[23:16] <= ram_rdata_i;
                        3'd4:    load_buf_r[31:24] <= ram_rdata_i;
                        default: ;
                    endcase
                    // >= keeps the sequencer bounded if the opcode changes mid-access.
                    if (k_r >= nbytes_s) begin
                        state_r <= ST_DONE;
                        k_r     <= 3'd0;
                    end else begin
                        k_r <= k_r + 3'd1;
                    end
                end
                ST_STORE: begin
                    if ((k_r + 3'd1) >= nbytes_s) begin
                        state_r <= ST_DONE;
                        k_r     <= 3'd0;
                    end else begin
                        k_r <= k_r + 3'd1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    k_r     <= 3'd0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    k_r     <= 3'd0;
                end
            endcase
        end
    end

    // Divide-by-2 clock output.
    always_ff @(posedge clk) begin
        if (rst) begin
            dclk_r <= 1'b0;
        end else begin
            dclk_r <= ~dclk_r;
        end
    end

    assign dclk = dclk_r;

    // Pipeline-side outputs and RAM requests per state; reset forces all low.
    always_comb begin
        stall_o  = 1'b0;
        wreg_o   = 1'b0;
        waddr_o  = 5'd0;
        wdata_o  = 32'd0;
        rd_req_s = 1'b0;
        wr_req_s = 1'b0;
        if (rst) begin
            stall_o = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!is_load_s && !is_store_s) begin
                        wreg_o  = wreg_i;
                        waddr_o = waddr_i;
                        wdata_o = alurslt_i;
                    end else begin
                        wreg_o = 1'b0;
                    end
                end
                ST_LOAD: begin
                    stall_o  = 1'b1;
                    rd_req_s = (k_r < nbytes_s);
                end
                ST_STORE: begin
                    stall_o  = 1'b1;
                    wr_req_s = 1'b1;
                end
                ST_DONE: begin
                    waddr_o = waddr_i;
                    if (is_load_s) begin
                        wreg_o  = wreg_i;
                        wdata_o = extend_load(aluop_i, load_buf_r);
                    end else begin
                        wreg_o = 1'b0;
                    end
                end
                default: begin
                    stall_o = 1'b0;
                end
            endcase
        end
    end

    // RAM port arbiter: a write request wins over a read request.
    always_comb begin
        ram_addr_o  = 32'd0;
        ram_wdata_o = 8'd0;
        ram_wr_o    = 1'b0;
        if (wr_req_s) begin
            ram_addr_o  = byte_addr_s;
            ram_wdata_o = store_byte_s;
            ram_wr_o    = 1'b1;
        end else if (rd_req_s) begin
            ram_addr_o = byte_addr_s;
        end else begin
            ram_addr_o = 32'd0;
        end
    end

endmodule

// File: tb/tb_mem_ram_access.sv
// Bench for mem_ram_access: directed scenarios followed by randomized
// store/load sequences, checked against a byte-addressed memory model and
// arithmetic expectations for extension, latency and RAM traffic.
module tb_mem_ram_access;

    localparam logic [5:0] ALU_LB  = 6'h20;
    localparam logic [5:0] ALU_LH  = 6'h21;
    localparam logic [5:0] ALU_LW  = 6'h22;
    localparam logic [5:0] ALU_LBU = 6'h23;
    localparam logic [5:0] ALU_LHU = 6'h24;
    localparam logic [5:0] ALU_SB  = 6'h25;
    localparam logic [5:0] ALU_SH  = 6'h26;
    localparam logic [5:0] ALU_SW  = 6'h27;

    logic        clk;
    logic        rst;
    logic [5:0]  aluop;
    logic        wreg;
    logic [4:0]  waddr;
    logic [31:0] alurslt;
    logic [31:0] storedata;
    logic [7:0]  ram_rdata;
    logic [31:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_wr;
    logic        stall;
    logic        wreg_out;
    logic [4:0]  waddr_out;
    logic [31:0] wdata_out;
    logic        dclk;

    int checks = 0;
    int errors = 0;

    // Environment RAM: 17-bit byte address, registered read.
    logic [7:0] env_ram [0:131071];
    // Reference image of what the stores should have left in memory.
    logic [7:0] ref_mem [int unsigned];

    mem_ram_access dut (
        .clk(clk), .rst(rst), .aluop_i(aluop), .wreg_i(wreg), .waddr_i(waddr),
        .alurslt_i(alurslt), .storedata_i(storedata), .ram_rdata_i(ram_rdata),
        .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_wr_o(ram_wr),
        .stall_o(stall), .wreg_o(wreg_out), .waddr_o(waddr_out),
        .wdata_o(wdata_out), .dclk(dclk)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (ram_wr) env_ram[ram_addr[16:0]] <= ram_wdata;
        ram_rdata <= env_ram[ram_addr[16:0]];
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int unsigned key(input logic [31:0] addr);
        return {15'd0, addr[16:0]};
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] addr);
        if (ref_mem.exists(key(addr))) return ref_mem[key(addr)];
        else return 8'h00;
    endfunction

    function automatic int op_bytes(input logic [5:0] op);
        if (op == ALU_LB || op == ALU_LBU || op == ALU_SB) return 1;
        else if (op == ALU_LH || op == ALU_LHU || op == ALU_SH) return 2;
        else return 4;
    endfunction

    // Expected load result: little-endian assembly, then extension.
    function automatic logic [31:0] exp_load(input logic [5:0] op, input logic [31:0] a);
        logic [31:0] v;
        v = 32'd0;
        for (int k = 0; k < op_bytes(op); k++)
            v = v + ({24'd0, ref_byte(a + k)} << (8 * k));
        if (op == ALU_LB && v >= 32'h80) v = v + 32'hFFFFFF00;
        if (op == ALU_LH && v >= 32'h8000) v = v + 32'hFFFF0000;
        return v;
    endfunction

    // Runs one memory op; entered and left just after a rising edge.
    task automatic run_mem(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd,
                           input logic wr, input logic [4:0] wa);
        int n;
        bit ld;
        int stalls;
        bit done;
        logic [31:0] expv;
        logic [31:0] sbyte;
        n  = op_bytes(op);
        ld = (op >= ALU_LB) && (op <= ALU_LHU);
        expv = ld ? exp_load(op, a) : 32'd0;
        if (!ld)
            for (int k = 0; k < n; k++) ref_mem[key(a + k)] = 8'((sd >> (8 * k)) & 32'hFF);
        aluop = op; alurslt = a; storedata = sd; wreg = wr; waddr = wa;
        @(negedge clk);
        chk("idle_ram_wr", {31'd0, ram_wr}, 32'd0);
        stalls = 0;
        done = 1'b0;
        for (int c = 0; c < 8 && !done; c++) begin
            @(negedge clk);
            if (stall) begin
                chk("stall_wreg", {31'd0, wreg_out}, 32'd0);
                if (stalls < n) begin
                    chk("ram_addr", ram_addr, a + 32'(stalls));
                    chk("ram_wr", {31'd0, ram_wr}, ld ? 32'd0 : 32'd1);
                    if (!ld) begin
                        sbyte = (sd >> (8 * stalls)) & 32'hFF;
                        chk("ram_wdata", {24'd0, ram_wdata}, sbyte);
                    end
                end else begin
                    chk("tail_addr", ram_addr, 32'd0);
                    chk("tail_wr", {31'd0, ram_wr}, 32'd0);
                end
                stalls++;
            end else begin
                done = 1'b1;
            end
        end
        chk("stall_cycles", 32'(stalls), ld ? 32'(n + 1) : 32'(n));
        chk("done_seen", {31'd0, done}, 32'd1);
        if (done) begin
            chk("wdata", wdata_out, expv);
            chk("wreg", {31'd0, wreg_out}, ld ? {31'd0, wr} : 32'd0);
            chk("waddr", {27'd0, waddr_out}, {27'd0, wa});
        end
        @(posedge clk);
        #1;
        aluop = 6'h00; wreg = 1'b0; alurslt = 32'd0;
    endtask

    initial begin
        logic [5:0] st_ops [3];
        logic [5:0] ld_ops [5];
        logic [31:0] a;
        int off;
        int n;
        st_ops = '{ALU_SB, ALU_SH, ALU_SW};
        ld_ops = '{ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU};
        rst = 1'b1; aluop = 6'h00; wreg = 1'b1; waddr = 5'd7;
        alurslt = 32'hDEADBEEF; storedata = 32'd0;

        // Reset forces every output low.
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_wreg", {31'd0, wreg_out}, 32'd0);
        chk("rst_waddr", {27'd0, waddr_out}, 32'd0);
        chk("rst_wdata", wdata_out, 32'd0);
        chk("rst_addr", ram_addr, 32'd0);
        chk("rst_wbyte", {24'd0, ram_wdata}, 32'd0);
        chk("rst_wr", {31'd0, ram_wr}, 32'd0);
        chk("rst_dclk", {31'd0, dclk}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; wreg = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("dclk", {31'd0, dclk}, 32'(i % 2));
        end
        @(posedge clk); #1;

        // Directed store/load image.
        run_mem(ALU_SW, 32'd0, 32'h0FF00FF0, 1'b1, 5'd1);
        chk("ram0", {24'd0, env_ram[0]}, 32'hF0);
        chk("ram1", {24'd0, env_ram[1]}, 32'h0F);
        chk("ram2", {24'd0, env_ram[2]}, 32'hF0);
        chk("ram3", {24'd0, env_ram[3]}, 32'h0F);
        run_mem(ALU_LW,  32'd0, 32'd0, 1'b1, 5'd2);
        run_mem(ALU_LB,  32'd0, 32'd0, 1'b1, 5'd3);
        run_mem(ALU_LBU, 32'd0, 32'd0, 1'b1, 5'd4);
        run_mem(ALU_LB,  32'd1, 32'd0, 1'b1, 5'd5);
        run_mem(ALU_LH,  32'd1, 32'd0, 1'b1, 5'd6);
        run_mem(ALU_LHU, 32'd1, 32'd0, 1'b1, 5'd7);
        run_mem(ALU_LH,  32'd0, 32'd0, 1'b1, 5'd8);

        // Non-memory op passes straight through in the same cycle.
        aluop = 6'h00; alurslt = 32'h12345678; waddr = 5'd5; wreg = 1'b1;
        #2;
        chk("nm_wdata", wdata_out, 32'h12345678);
        chk("nm_waddr", {27'd0, waddr_out}, 32'd5);
        chk("nm_wreg", {31'd0, wreg_out}, 32'd1);
        chk("nm_stall", {31'd0, stall}, 32'd0);
        chk("nm_wr", {31'd0, ram_wr}, 32'd0);
        @(posedge clk); #1;

        // Reset during cycle 2 of an LW aborts it.
        aluop = ALU_LW; alurslt = 32'd0; wreg = 1'b1; waddr = 5'd9;
        @(posedge clk); @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_stall", {31'd0, stall}, 32'd0);
        chk("mrst_wreg", {31'd0, wreg_out}, 32'd0);
        chk("mrst_waddr", {27'd0, waddr_out}, 32'd0);
        chk("mrst_wdata", wdata_out, 32'd0);
        chk("mrst_addr", ram_addr, 32'd0);
        chk("mrst_wbyte", {24'd0, ram_wdata}, 32'd0);
        chk("mrst_wr", {31'd0, ram_wr}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; aluop = 6'h00; alurslt = 32'h00000055; wreg = 1'b0;
        @(negedge clk);
        chk("post_rst_stall", {31'd0, stall}, 32'd0);
        chk("post_rst_idle", wdata_out, 32'h00000055);
        @(posedge clk); #1;
        run_mem(ALU_LW, 32'd0, 32'd0, 1'b1, 5'd10);

        // Randomized: word store, narrower overwrite, load within the word.
        for (int it = 0; it < 20; it++) begin
            a = $urandom;
            if (it == 0) a = 32'hFFFFFFFE;
            run_mem(ALU_SW, a, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
            n = $urandom_range(0, 2);
            off = $urandom_range(0, 4 - op_bytes(st_ops[n]));
            run_mem(st_ops[n], a + 32'(off), $urandom, 1'b1, 5'($urandom_range(0, 31)));
            n = $urandom_range(0, 4);
            off = $urandom_range(0, 4 - op_bytes(ld_ops[n]));
            run_mem(ld_ops[n], a + 32'(off), $urandom, 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 31)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
